// File: rtl/tdc_multihit_ctrl.sv
// rtl/tdc_multihit_ctrl.sv - multi-channel multi-hit TDC back-end with round-robin result FIFO
// Optional macro TDC_TIMESTAMP_EN appends the rise timestamp {rise_coarse, rise_fine} to each word.
module tdc_multihit_ctrl #(
    parameter int N_CH     = 4,
    parameter int FINE_W   = 6,
    parameter int BINS     = 48,
    parameter int COARSE_W = 10,
    parameter int DEPTH    = 16,
    parameter int DEAD_CYC = 4,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int W_W     = COARSE_W + FINE_W,
`ifdef TDC_TIMESTAMP_EN
    localparam int OUT_W   = 1 + CH_W + COARSE_W + FINE_W + W_W
`else
    localparam int OUT_W   = 1 + CH_W + W_W
`endif
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [N_CH-1:0]          iRise,
    input  logic [N_CH-1:0]          iFall,
    input  logic [N_CH*FINE_W-1:0]   iFineRise,
    input  logic [N_CH*FINE_W-1:0]   iFineFall,
    output logic [N_CH-1:0]          oArm,
    output logic [OUT_W-1:0]         oData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [15:0]              oLost,
    output logic                     oFull
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DCW = $clog2(DEAD_CYC + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [1:0] S_DEAD = 2'd3;

    logic [1:0]          warm;
    logic                ready;
    logic [COARSE_W-1:0] coarse;
    logic [CH_W-1:0]     rr_ptr;

    logic [N_CH-1:0]     pend;
    logic [N_CH-1:0]     res_ovf;
    logic [W_W-1:0]      res_width [N_CH];
`ifdef TDC_TIMESTAMP_EN
    logic [COARSE_W-1:0] res_rc [N_CH];
    logic [FINE_W-1:0]   res_rf [N_CH];
`endif
    logic [N_CH-1:0]     lost_vec;

    logic                gnt_vld;
    logic [CH_W-1:0]     gnt_ch;
    logic [CH_W-1:0]     cand;

    assign ready = warm[1];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            warm   <= 2'b00;
            coarse <= '0;
        end else begin
            warm   <= {warm[0], 1'b1};
            coarse <= coarse + 1'b1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [1:0]          state_q;
        logic                calc_q;
        logic                ovf_q;
        logic [COARSE_W-1:0] rise_coarse_q;
        logic [COARSE_W-1:0] el_fin_q;
        logic [FINE_W-1:0]   fine_r_q;
        logic [FINE_W-1:0]   fine_f_q;
        logic [W_W-1:0]      width_q;
        logic [DCW-1:0]      dcnt_q;
        logic [COARSE_W-1:0] elapsed;
        logic [W_W:0]        sum;
        logic [W_W:0]        fall_ext;
        logic [W_W-1:0]      width_d;
        logic [FINE_W-1:0]   fr_in;
        logic [FINE_W-1:0]   ff_in;

        assign fr_in    = iFineRise[k*FINE_W +: FINE_W];
        assign ff_in    = iFineFall[k*FINE_W +: FINE_W];
        // Latched rise coarse doubles as the elapsed reference; subtraction wraps naturally.
        assign elapsed  = coarse - rise_coarse_q;
        assign sum      = (W_W+1)'(el_fin_q) * (W_W+1)'(BINS) + (W_W+1)'(fine_r_q);
        assign fall_ext = (W_W+1)'(fine_f_q);
        assign width_d  = (sum < fall_ext) ? '0 : W_W'(sum - fall_ext);

        assign oArm[k]      = ready && (state_q == S_IDLE);
        assign pend[k]      = (state_q == S_PEND);
        assign lost_vec[k]  = iRise[k] && !oArm[k];
        assign res_ovf[k]   = ovf_q;
        assign res_width[k] = width_q;
`ifdef TDC_TIMESTAMP_EN
        assign res_rc[k]    = rise_coarse_q;
        assign res_rf[k]    = fine_r_q;
`endif

        always_ff @(posedge iClk) begin
            if (iRst) begin
                state_q       <= S_IDLE;
                calc_q        <= 1'b0;
                ovf_q         <= 1'b0;
                rise_coarse_q <= '0;
                el_fin_q      <= '0;
                fine_r_q      <= '0;
                fine_f_q      <= '0;
                width_q       <= '0;
                dcnt_q        <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (iRise[k] && ready) begin
                            state_q       <= S_RUN;
                            rise_coarse_q <= coarse;
                            fine_r_q      <= fr_in;
                            fine_f_q      <= ff_in;
                            el_fin_q      <= '0;
                            ovf_q         <= 1'b0;
                            calc_q        <= iFall[k];
                        end
                    end
                    S_RUN: begin
                        // calc_q marks the extra cycle in which width is registered.
                        if (calc_q) begin
                            calc_q  <= 1'b0;
                            state_q <= S_PEND;
                            width_q <= ovf_q ? '1 : width_d;
                        end else if (iFall[k]) begin
                            calc_q   <= 1'b1;
                            el_fin_q <= elapsed;
                            fine_f_q <= ff_in;
                        end else if (elapsed == '1) begin
                            calc_q <= 1'b1;
                            ovf_q  <= 1'b1;
                        end
                    end
                    S_PEND: begin
                        if (gnt_vld && (gnt_ch == CH_W'(k))) begin
                            state_q <= S_DEAD;
                            dcnt_q  <= DCW'(DEAD_CYC);
                        end
                    end
                    S_DEAD: begin
                        if (dcnt_q <= DCW'(1)) state_q <= S_IDLE;
                        else dcnt_q <= dcnt_q - 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Lowest offset from rr_ptr wins, so scan offsets from high to low.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = CH_W'((int'(rr_ptr) + i) % N_CH);
            if (pend[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
        if (oFull) gnt_vld = 1'b0;
    end

    always_ff @(posedge iClk) begin
        if (iRst) rr_ptr <= '0;
        else if (gnt_vld) rr_ptr <= CH_W'((int'(gnt_ch) + 1) % N_CH);
    end

    logic [4:0]  lost_inc;
    logic [16:0] lost_sum;

    always_comb begin
        lost_inc = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (lost_vec[i]) lost_inc = lost_inc + 5'd1;
        end
    end

    assign lost_sum = {1'b0, oLost} + 17'(lost_inc);

    always_ff @(posedge iClk) begin
        if (iRst) oLost <= '0;
        else if (lost_sum[16]) oLost <= 16'hFFFF;
        else oLost <= lost_sum[15:0];
    end

    logic [OUT_W-1:0] mem [DEPTH];
    logic [OUT_W-1:0] wdata;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    always_comb begin
`ifdef TDC_TIMESTAMP_EN
        wdata = {res_ovf[gnt_ch], gnt_ch, res_rc[gnt_ch], res_rf[gnt_ch], res_width[gnt_ch]};
`else
        wdata = {res_ovf[gnt_ch], gnt_ch, res_width[gnt_ch]};
`endif
    end

    assign push   = gnt_vld;
    assign pop    = oValid && iReady;
    assign oValid = (count != '0);
    assign oFull  = (count == (AW+1)'(DEPTH));
    assign oData  = mem[rd_ptr];

    always_ff @(posedge iClk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_multihit_ctrl.sv
// tb/tb_tdc_multihit_ctrl.sv - self-checking bench for tdc_multihit_ctrl
module tb_tdc_multihit_ctrl;

    localparam int TB_BINS = 48;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [3:0]  iRise = '0;
    logic [3:0]  iFall = '0;
    logic [23:0] iFineRise = '0;
    logic [23:0] iFineFall = '0;
    logic        iReady = 1'b0;
    logic [3:0]  oArm;
    logic [18:0] oData;
    logic        oValid;
    logic [15:0] oLost;
    logic        oFull;

    tdc_multihit_ctrl dut (
        .iClk(iClk), .iRst(iRst), .iRise(iRise), .iFall(iFall),
        .iFineRise(iFineRise), .iFineFall(iFineFall), .oArm(oArm),
        .oData(oData), .oValid(oValid), .iReady(iReady),
        .oLost(oLost), .oFull(oFull)
    );

    always #5 iClk = ~iClk;

    int n_chk = 0;
    int n_fail = 0;
    int exp_lost = 0;
    logic [18:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Width from the pulse description: edges elapsed between rise and fall, in tap bins.
    function automatic int model_width(input int el, input int fr, input int ff);
        int w;
        w = el * TB_BINS + fr - ff;
        return (w < 0) ? 0 : w;
    endfunction

    function automatic logic [18:0] mk(input logic ovf, input int ch, input int w);
        logic [1:0]  c;
        logic [15:0] wv;
        c  = 2'(ch);
        wv = 16'(w);
        return {ovf, c, wv};
    endfunction

    always @(negedge iClk) begin
        if (!iRst && oValid && iReady) begin
            if (exp_q.size() == 0) check("fifo_unexpected_word", 32'(exp_q.size()), 32'd1);
            else check("fifo_word", 32'(oData), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        iRst = 1'b1; iRise = '0; iFall = '0;
        exp_q.delete();
        exp_lost = 0;
        tick();
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_full", 32'(oFull), 32'd0);
        check("rst_lost", 32'(oLost), 32'd0);
        check("rst_arm", 32'(oArm), 32'd0);
        iRst = 1'b0;
        tick();
        check("warm1_arm", 32'(oArm), 32'd0);
        tick();
        check("warm2_arm", 32'(oArm), 32'hF);
    endtask

    task automatic wait_arm(input int ch);
        for (int i = 0; i < 60; i++) begin
            if (oArm[ch]) break;
            tick();
        end
        check("arm_wait", 32'(oArm[ch]), 32'd1);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse(input int ch, input int gap, input int fr, input int ff);
        wait_arm(ch);
        tick();
        iRise[ch] = 1'b1;
        iFineRise[ch*6 +: 6] = 6'(fr);
        iFineFall[ch*6 +: 6] = 6'(ff);
        if (gap == 0) iFall[ch] = 1'b1;
        tick();
        iRise[ch] = 1'b0;
        iFall[ch] = 1'b0;
        if (gap > 0) begin
            repeat (gap - 1) tick();
            iFall[ch] = 1'b1;
            tick();
            iFall[ch] = 1'b0;
        end
        exp_q.push_back(mk(1'b0, ch, model_width(gap, fr, ff)));
    endtask

    int fr4 [4];
    int ff4 [4];
    int g;

    initial begin
        do_reset();
        iReady = 1'b1;

        // Directed single pulse on ch0: latency, width and dead-time re-arm.
        tick();
        iRise[0] = 1'b1; iFineRise[5:0] = 6'd20; iFineFall[5:0] = 6'd5;
        tick();
        iRise[0] = 1'b0;
        check("t1_arm_after_rise", 32'(oArm[0]), 32'd0);
        repeat (2) tick();
        iFall[0] = 1'b1;
        tick();
        iFall[0] = 1'b0;
        exp_q.push_back(mk(1'b0, 0, 159));
        check("t1_valid_f0", 32'(oValid), 32'd0);
        tick();
        check("t1_valid_f1", 32'(oValid), 32'd0);
        tick();
        check("t1_valid_f2", 32'(oValid), 32'd1);
        check("t1_data", 32'(oData), 32'(mk(1'b0, 0, 159)));
        repeat (3) tick();
        check("t1_dead_arm", 32'(oArm[0]), 32'd0);
        tick();
        check("t1_rearm", 32'(oArm[0]), 32'd1);
        wait_drain(20);

        // Same-cycle rise/fall on ch1, positive and clamped widths.
        pulse(1, 0, 30, 12);
        pulse(1, 0, 5, 12);
        wait_drain(20);

        // Timeout on ch2.
        wait_arm(2);
        tick();
        iRise[2] = 1'b1;
        tick();
        iRise[2] = 1'b0;
        exp_q.push_back(mk(1'b1, 2, 16'hFFFF));
        wait_drain(1200);

        // Randomized sequential pulses.
        for (int i = 0; i < 12; i++) begin
            pulse($urandom_range(0, 3), $urandom_range(0, 8),
                  $urandom_range(0, TB_BINS - 1), $urandom_range(0, TB_BINS - 1));
        end
        wait_drain(50);

        // Simultaneous falls on all channels after reset: round-robin from ch0, twice.
        do_reset();
        iReady = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 60; i++) begin
                if (oArm == 4'hF) break;
                tick();
            end
            check("t4_all_armed", 32'(oArm), 32'hF);
            g = $urandom_range(1, 6);
            tick();
            for (int c = 0; c < 4; c++) begin
                fr4[c] = $urandom_range(0, TB_BINS - 1);
                ff4[c] = $urandom_range(0, TB_BINS - 1);
                iFineRise[c*6 +: 6] = 6'(fr4[c]);
                iFineFall[c*6 +: 6] = 6'(ff4[c]);
            end
            iRise = 4'hF;
            tick();
            iRise = 4'h0;
            repeat (g - 1) tick();
            iFall = 4'hF;
            tick();
            iFall = 4'h0;
            for (int c = 0; c < 4; c++) exp_q.push_back(mk(1'b0, c, model_width(g, fr4[c], ff4[c])));
            wait_drain(50);
        end

        // Backpressure: 17 pulses with the consumer stalled.
        iReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pulse(i % 4, $urandom_range(1, 4), $urandom_range(0, TB_BINS - 1), $urandom_range(0, TB_BINS - 1));
        end
        repeat (4) tick();
        check("t5_full_16", 32'(oFull), 32'd1);
        pulse(0, $urandom_range(1, 4), $urandom_range(0, TB_BINS - 1), $urandom_range(0, TB_BINS - 1));
        repeat (6) tick();
        check("t5_pend_arm", 32'(oArm[0]), 32'd0);
        check("t5_still_full", 32'(oFull), 32'd1);
        iRise[0] = 1'b1;
        tick();
        iRise[0] = 1'b0;
        exp_lost++;
        tick();
        check("t5_lost", 32'(oLost), 32'(exp_lost));
        iReady = 1'b1;
        wait_drain(100);
        tick();
        check("t5_drained_full", 32'(oFull), 32'd0);
        check("t5_drained_valid", 32'(oValid), 32'd0);

        // Reset while ch0 is running and three words are queued.
        iReady = 1'b0;
        pulse(1, 2, 10, 3);
        pulse(2, 1, 40, 2);
        pulse(3, 3, 7, 30);
        repeat (4) tick();
        check("t6_valid", 32'(oValid), 32'd1);
        wait_arm(0);
        tick();
        iRise[0] = 1'b1;
        tick();
        iRise[0] = 1'b0;
        check("t6_run_arm", 32'(oArm[0]), 32'd0);
        tick();
        iRise[0] = 1'b1;
        tick();
        iRise[0] = 1'b0;
        exp_lost++;
        tick();
        check("t6_lost", 32'(oLost), 32'(exp_lost));
        do_reset();
        iReady = 1'b1;
        repeat (5) tick();
        check("t6_after_valid", 32'(oValid), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_multihit_ctrl.md
Name: tdc_multihit_ctrl

Overview:
Multi-channel, multi-hit back-end for the carry-chain TDC. Each channel receives rise/fall strobes with decoded fine codes from its edge detector and fine decoders. The block timestamps each pulse against a shared coarse counter, computes pulse width in tap bins, and queues results in an output FIFO read with valid/ready. It replaces the single-shot merge/self-reset scheme with per-channel re-arming after a programmable dead time.

Parameters:
N_CH, 4, number of input channels (1..16)
FINE_W, 6, fine code width
BINS, 48, taps per clock period; fine codes range 0..BINS-1; BINS <= 2^FINE_W
COARSE_W, 10, coarse counter width; also the timeout limit
DEPTH, 16, FIFO depth, power of 2
DEAD_CYC, 4, dead-time cycles after a result is queued (>=1)

Ports:
iClk  in  1  clock
iRst  in  1  synchronous active-high reset
iRise  in  N_CH  per-channel rise strobe, one-cycle pulse
iFall  in  N_CH  per-channel fall strobe, one-cycle pulse
iFineRise  in  N_CH*FINE_W  rise fine code; channel k in bits [k*FINE_W +: FINE_W]
iFineFall  in  N_CH*FINE_W  fall fine code, same packing
oArm  out  N_CH  per-channel front-end enable
oData  out  OUT_W  {ovf, ch_id[CH_W], width[COARSE_W+FINE_W]}; CH_W = max(1, clog2(N_CH))
oValid  out  1  FIFO head valid
iReady  in  1  consumer accepts head
oLost  out  16  saturating count of rises ignored
oFull  out  1  FIFO full

Behaviour:
- Reset (iRst high at a clock edge): all channels IDLE; FIFO empty; oValid=0; oFull=0; oLost=0; oArm=0; coarse counter=0; round-robin pointer=0; warm-up shift register cleared.
- Warm-up: 2-stage ready register. oArm goes high on the 2nd edge after iRst deasserts.
- Coarse counter: free-running COARSE_W bits, wraps modulo 2^COARSE_W.
- Event time: t = coarse*BINS - fine.
- Channel FSM, per channel: IDLE, RUN, PEND, DEAD.
  - oArm[k] = ready & (state==IDLE).
  - IDLE, iRise & ready: latch coarse and rise fine code; clear elapsed counter; go to RUN.
  - IDLE, iRise & iFall in the same cycle: width = max(0, fineRise - fineFall); go to PEND.
  - IDLE, iFall alone: ignored.
  - RUN: elapsed counter increments each cycle.
    - iFall: width = elapsed*BINS + fineRise - fineFall. elapsed is the number of edges between rise and fall, computed modulo 2^COARSE_W. A negative result clamps to 0. ovf=0. Go to PEND.
    - Elapsed reaches 2^COARSE_W-1 with no fall: width = all ones, ovf=1, go to PEND.
    - iRise while in RUN: ignored and counted.
  - PEND: wait for grant. On grant go to DEAD with a down-counter loaded with DEAD_CYC. Leave DEAD for IDLE when the counter reaches 0.
  - iRise while not IDLE, or before ready: oLost increments, saturating at 0xFFFF.
- Width is computed in a registered stage. Fall at edge t gives PEND from t+1.
- Arbiter: round-robin across PEND channels, one grant per cycle, only when the FIFO is not full. Search starts at the channel after the last granted one. Grant writes the FIFO on that edge.
- Latency: fall at edge t, FIFO empty, no contention gives oValid=1 at t+2.
- FIFO: show-ahead. oData is stable while oValid=1 and iReady=0. Pop on oValid & iReady.
  - Write while full: not possible, because grant is blocked and the channel holds in PEND (backpressure).
  - Read and write in the same cycle: both happen; count unchanged.
  - Pointers wrap modulo DEPTH. oFull = (count==DEPTH).
- Reset mid-operation: immediate abort. Pending results and FIFO contents are discarded and the warm-up restarts.

Optional Feature:
TDC_TIMESTAMP_EN
- Defined: oData is extended to {ovf, ch_id, rise_coarse[COARSE_W], rise_fine[FINE_W], width}. The rise timestamp is latched at the IDLE→RUN transition; for same-cycle rise/fall it is the coarse value at that cycle.
- Undefined: these fields and their registers are absent; oData is as in Ports.

Test Plan:
1. Reset, release; ch0 rise at coarse 10 with fineRise=20, fall 3 cycles later with fineFall=5, iReady=1 → oArm[0] low from the cycle after rise; oData={0,0,3*48+15=159} with oValid at fall+2; oArm[0] returns high DEAD_CYC cycles after the grant.
2. ch1 rise and fall in the same cycle, fineRise=30, fineFall=12 → width 18; fineRise=5, fineFall=12 → width 0.
3. ch2 rise with no fall → after 1023 cycles, word {1,2,0xFFFF}.
4. ch0..ch3 fall in the same cycle, pointer=0 → output order ch0, ch1, ch2, ch3 on consecutive cycles; next simultaneous batch starts at ch0 after ch3 was last granted.
5. iReady=0, 17 pulses across channels → oFull=1 after 16; the 17th channel stays PEND with oArm low and its rises increment oLost; raising iReady drains 17 words in order.
6. Assert iRst while ch0 is in RUN and the FIFO holds 3 words → the next cycle has oValid=0, oLost=0, oArm=0; oArm=1 on the 2nd edge after release.
